instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Host-side writer for the autoencoder's 32-entry, 16-bit instruction memory; it is the producer end of the instruction fetch path.
- Accepts a program from a host over a valid/ready stream and writes it word by word into instruction memory.
- Then releases the core to run it, and detects program end from the fetched opcode or a program-length bound.
- Sits between the host/testbench and the instruction memory plus PC counter.

Parameters:
- ADDR_W, 5, instruction memory address width; DEPTH = 2**ADDR_W = 32 words.
- DATA_W, 16, instruction width: opcode[15:12], fields [11:8], [7:4], [3:0].
- HALT_OP, 4'hF, opcode that terminates execution.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- load_req  in  1  pulse: start accepting a new program.
- s_valid  in  1  host word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  DATA_W  instruction word.
- s_last  in  1  marks the final word of the program.
- start  in  1  pulse: run the loaded program.
- abort  in  1  stop the run immediately.
- imem_we  out  1  instruction memory write enable.
- imem_waddr  out  ADDR_W  write address.
- imem_wdata  out  DATA_W  write data.
- core_pc  in  ADDR_W  current PC (counter value).
- core_opcode  in  4  opcode of the instruction currently fetched, i.e. instruction[15:12].
- pc_clr  out  1  one-cycle pulse that clears the PC counter.
- core_run  out  1  enables PC advance, ALU and memory writes.
- prog_len  out  ADDR_W+1  number of words loaded (1..32).
- loaded  out  1  a valid program is resident.
- done  out  1  one-cycle pulse at normal program end.
- overflow  out  1  sticky: DEPTH words accepted without s_last.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE; wr_ptr=0, prog_len=0.
  - All outputs are 0: s_ready, imem_we, imem_waddr, imem_wdata, pc_clr, core_run, loaded, done, overflow.
- IDLE:
  - s_ready=0.
  - load_req → LOAD, with wr_ptr←0, loaded←0, overflow←0.
  - start is ignored.
- LOAD:
  - s_ready=1. A beat is accepted on a rising edge with s_valid&s_ready.
  - Accepted beat at edge k: in the cycle after edge k, imem_we=1, imem_waddr=wr_ptr(old), imem_wdata=s_data. Write latency is 1 cycle, registered.
  - wr_ptr increments per beat.
  - Accepted beat with s_last: prog_len←wr_ptr+1, loaded←1, next state LOADED. s_ready drops in the next cycle.
  - Accepted beat at wr_ptr=DEPTH-1 without s_last: overflow←1, loaded←0, next state IDLE. The word is still written.
  - load_req while in LOAD restarts with wr_ptr←0; a beat accepted in that same cycle is dropped, not written.
- LOADED:
  - s_ready=0.
  - start → RUN, with pc_clr=1 for exactly the first RUN cycle and core_run=0 in that cycle.
  - load_req → LOAD (program discarded, loaded←0).
  - If start and load_req arrive together, load_req wins.
- RUN:
  - core_run=1 from the second RUN cycle onward.
  - Program end is detected when core_run=1 and either:
    - core_opcode==HALT_OP, or
    - core_pc==prog_len-1 (last instruction; it executes this cycle).
  - On program end: core_run←0 at the next edge, done=1 for one cycle, then state LOADED; the program is retained, so start reruns it.
  - abort → LOADED at the next edge, core_run←0, no done pulse.
  - load_req is ignored in RUN.
- Width rules:
  - wr_ptr is ADDR_W+1 bits so that the count 32 is representable.
  - prog_len-1 is compared on ADDR_W bits.
  - core_pc wrap is never relied on; the end condition always fires first.
- Reset mid-LOAD or mid-RUN discards everything: loaded=0, and a reload is required.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, LOAD=2'd1, LOADED=2'd2, RUN=2'd3;
  - HALT_OP;
  - the opcode field slice constants [15:12], so the CU and the loader agree.
- One natural sub-module, loader_wr_port: the registered write stage (we/addr/data pipeline register plus wr_ptr counter). FSM and run control stay in the top.

Test Plan:
- Reset during LOAD after 3 beats → all outputs 0 immediately, loaded=0; a following load_req restarts writes at address 0.
- load_req, then 4 beats 16'h1123, 16'h2456, 16'h3789, 16'hF000 (last on 4th) → imem_we high on 4 cycles, addresses 0..3 each 1 cycle after its beat, prog_len=4, loaded=1.
- Host drops s_valid for 2 cycles mid-program → no writes in the gap, addresses stay contiguous, prog_len correct.
- 32 beats without s_last → overflow=1, loaded=0, state IDLE, s_ready=0; a subsequent start has no effect.
- Loaded length 4, start, PC counts 0..3, opcode never HALT_OP → pc_clr 1 cycle, core_run high until PC=3 cycle, done pulses once, rerun via start behaves identically.
- In RUN, core_opcode=4'hF at PC=1 → core_run drops the next cycle, done=1. Separately, abort at PC=2 → core_run drops, done stays 0, loaded remains 1.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared constants and types for the instruction loader and its consumers.
package instr_loader_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned OP_W   = 4;

  // Opcode field position inside an instruction word, shared with the CU.
  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;

  localparam logic [OP_W-1:0] HALT_OP = 4'hF;

  // State encodings.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_LOADED = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = S_IDLE,
    LOAD   = S_LOAD,
    LOADED = S_LOADED,
    RUN    = S_RUN
  } state_e;

  // Extract the opcode field from an instruction word.
  function automatic logic [OP_W-1:0] opcode_of(input logic [DATA_W-1:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Host-to-loader valid/ready program stream.
//   s_valid : host word valid
//   s_ready : loader can accept a word
//   s_data  : instruction word
//   s_last  : final word of the program
interface instr_loader_if;
  import instr_loader_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/instr_loader_wr_port.sv
// Registered instruction-memory write stage and write pointer.
//   clock, reset_n : clock / async active-low reset
//   clr            : reset write pointer to 0 (beat must be 0)
//   beat           : accepted word this cycle
//   data           : word to write
//   imem_we/waddr/wdata : registered write to instruction memory
//   wr_ptr         : number of words written so far (0..DEPTH)
module instr_loader_wr_port
  import instr_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              beat,
  input  logic [DATA_W-1:0] data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic [PTR_W-1:0]  wr_ptr
);

  // Write lands one cycle after the beat, at the pre-increment pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      wr_ptr     <= '0;
    end else begin
      imem_we <= beat;
      if (beat) begin
        imem_waddr <= ADDR_W'(wr_ptr);
        imem_wdata <= data;
      end
      if (clr) begin
        wr_ptr <= '0;
      end else if (beat) begin
        wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads a host program into instruction memory, then runs it and detects its end.
//   clock, reset_n      : clock / async active-low reset
//   s                   : host program stream (slave)
//   load_req, start     : pulses to begin loading / run the resident program
//   abort               : stop a run without a done pulse
//   imem_we/waddr/wdata : instruction memory write port
//   core_pc, core_opcode: current PC and fetched opcode
//   pc_clr, core_run    : PC clear pulse / core execution enable
//   prog_len, loaded    : resident program length and validity
//   done, overflow      : normal-end pulse / sticky over-length flag
module instr_loader
  import instr_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  instr_loader_if.slave     s,
  input  logic              load_req,
  input  logic              start,
  input  logic              abort,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic [ADDR_W-1:0] core_pc,
  input  logic [OP_W-1:0]   core_opcode,
  output logic              pc_clr,
  output logic              core_run,
  output logic [PTR_W-1:0]  prog_len,
  output logic              loaded,
  output logic              done,
  output logic              overflow
);

  state_e            state, state_nx;
  logic              s_ready_q;
  logic              s_ready_nx, pc_clr_nx, core_run_nx, loaded_nx, done_nx, overflow_nx;
  logic [PTR_W-1:0]  prog_len_nx;
  logic [PTR_W-1:0]  wr_ptr;
  logic              wp_clr, wp_beat;
  logic              beat_c, end_c;

  assign s.s_ready = s_ready_q;
  assign beat_c    = s.s_valid & s_ready_q;

  // The last instruction executes in the cycle core_pc reaches prog_len-1.
  assign end_c = core_run &&
                 ((core_opcode == HALT_OP) || (core_pc == ADDR_W'(prog_len - 1'b1)));

  instr_loader_wr_port u_wr_port (
    .clock      (clock),
    .reset_n    (reset_n),
    .clr        (wp_clr),
    .beat       (wp_beat),
    .data       (s.s_data),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .wr_ptr     (wr_ptr)
  );

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      s_ready_q <= 1'b0;
      pc_clr    <= 1'b0;
      core_run  <= 1'b0;
      prog_len  <= '0;
      loaded    <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nx;
      s_ready_q <= s_ready_nx;
      pc_clr    <= pc_clr_nx;
      core_run  <= core_run_nx;
      prog_len  <= prog_len_nx;
      loaded    <= loaded_nx;
      done      <= done_nx;
      overflow  <= overflow_nx;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_nx    = state;
    wp_clr      = 1'b0;
    wp_beat     = 1'b0;
    pc_clr_nx   = 1'b0;
    core_run_nx = 1'b0;
    done_nx     = 1'b0;
    loaded_nx   = loaded;
    overflow_nx = overflow;
    prog_len_nx = prog_len;

    case (state)
      IDLE: begin
        if (load_req) begin
          state_nx    = LOAD;
          wp_clr      = 1'b1;
          loaded_nx   = 1'b0;
          overflow_nx = 1'b0;
        end
      end
      LOAD: begin
        if (load_req) begin
          // Restart; a beat in this same cycle is dropped.
          wp_clr    = 1'b1;
          loaded_nx = 1'b0;
        end else if (beat_c) begin
          wp_beat = 1'b1;
          if (s.s_last) begin
            prog_len_nx = PTR_W'(wr_ptr + 1'b1);
            loaded_nx   = 1'b1;
            state_nx    = LOADED;
          end else if (wr_ptr == PTR_W'(DEPTH - 1)) begin
            overflow_nx = 1'b1;
            loaded_nx   = 1'b0;
            state_nx    = IDLE;
          end
        end
      end
      LOADED: begin
        if (load_req) begin
          state_nx  = LOAD;
          wp_clr    = 1'b1;
          loaded_nx = 1'b0;
        end else if (start) begin
          state_nx  = RUN;
          pc_clr_nx = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = LOADED;
        end else if (end_c) begin
          state_nx = LOADED;
          done_nx  = 1'b1;
        end else begin
          core_run_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    s_ready_nx = (state_nx == LOAD);
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader.
module tb_instr_loader;
  import instr_loader_pkg::*;

  logic              clock;
  logic              reset_n;
  logic              load_req, start, abort;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [DATA_W-1:0] imem_wdata;
  logic [ADDR_W-1:0] core_pc;
  logic [OP_W-1:0]   core_opcode;
  logic              pc_clr, core_run;
  logic [PTR_W-1:0]  prog_len;
  logic              loaded, done, overflow;

  logic              halt_en;
  logic [ADDR_W-1:0] halt_pc;

  int checks   = 0;
  int failures = 0;

  instr_loader_if hs ();

  instr_loader dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .s           (hs),
    .load_req    (load_req),
    .start       (start),
    .abort       (abort),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .core_pc     (core_pc),
    .core_opcode (core_opcode),
    .pc_clr      (pc_clr),
    .core_run    (core_run),
    .prog_len    (prog_len),
    .loaded      (loaded),
    .done        (done),
    .overflow    (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment PC counter driven by pc_clr / core_run.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)     core_pc <= '0;
    else if (pc_clr)  core_pc <= '0;
    else if (core_run) core_pc <= ADDR_W'(core_pc + 1'b1);
  end

  assign core_opcode = (halt_en && core_pc == halt_pc) ? opcode_of(16'hF000)
                                                       : opcode_of(16'h1123);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One accepted beat; the write must appear in the cycle after the edge.
  task automatic send_beat(input logic [DATA_W-1:0] w, input logic last,
                           input logic [ADDR_W-1:0] exp_addr);
    hs.s_valid = 1'b1;
    hs.s_data  = w;
    hs.s_last  = last;
    tick();
    hs.s_valid = 1'b0;
    hs.s_last  = 1'b0;
    chk("we", 32'(imem_we), 32'd1);
    chk("waddr", 32'(imem_waddr), 32'(exp_addr));
    chk("wdata", 32'(imem_wdata), 32'(w));
  endtask

  task automatic load4();
    pulse_load();
    chk("s_ready_load", 32'(hs.s_ready), 32'd1);
    send_beat(16'h1123, 1'b0, 5'd0);
    send_beat(16'h2456, 1'b0, 5'd1);
    send_beat(16'h3789, 1'b0, 5'd2);
    send_beat(16'hF000, 1'b1, 5'd3);
    chk("s_ready_after_last", 32'(hs.s_ready), 32'd0);
    chk("prog_len4", 32'(prog_len), 32'd4);
    chk("loaded4", 32'(loaded), 32'd1);
    tick();
    chk("we_idle", 32'(imem_we), 32'd0);
  endtask

  // Length-4 program, PC 0..3, no HALT opcode seen.
  task automatic run_plain();
    pulse_start();
    chk("pc_clr_first", 32'(pc_clr), 32'd1);
    chk("run_first", 32'(core_run), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("run_on", 32'(core_run), 32'd1);
      chk("pc_clr_off", 32'(pc_clr), 32'd0);
      chk("done_early", 32'(done), 32'd0);
    end
    tick();
    chk("run_end", 32'(core_run), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("loaded_kept", 32'(loaded), 32'd1);
    tick();
    chk("done_once", 32'(done), 32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    load_req   = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    halt_en    = 1'b0;
    halt_pc    = '0;
    hs.s_valid = 1'b0;
    hs.s_data  = '0;
    hs.s_last  = 1'b0;
    #12;
    chk("rst_s_ready", 32'(hs.s_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_run", 32'(core_run), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_prog_len", 32'(prog_len), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    tick();

    // Reset in the middle of a load.
    pulse_load();
    send_beat(16'hAAAA, 1'b0, 5'd0);
    send_beat(16'hBBBB, 1'b0, 5'd1);
    hs.s_valid = 1'b1;
    hs.s_data  = 16'hCCCC;
    tick();
    reset_n = 1'b0;
    #1;
    hs.s_valid = 1'b0;
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_ready", 32'(hs.s_ready), 32'd0);
    chk("mid_rst_loaded", 32'(loaded), 32'd0);
    chk("mid_rst_waddr", 32'(imem_waddr), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Basic 4-word load restarting at address 0.
    load4();

    // Start and load_req together in LOADED: load wins.
    load_req = 1'b1;
    start    = 1'b1;
    tick();
    load_req = 1'b0;
    start    = 1'b0;
    chk("both_ready", 32'(hs.s_ready), 32'd1);
    chk("both_pc_clr", 32'(pc_clr), 32'd0);
    chk("both_loaded", 32'(loaded), 32'd0);

    // Beat coinciding with a restart is dropped.
    send_beat(16'h1111, 1'b0, 5'd0);
    load_req   = 1'b1;
    hs.s_valid = 1'b1;
    hs.s_data  = 16'h2222;
    tick();
    load_req   = 1'b0;
    hs.s_valid = 1'b0;
    chk("restart_drop_we", 32'(imem_we), 32'd0);

    // Gap in s_valid; addresses stay contiguous.
    send_beat(16'h0001, 1'b0, 5'd0);
    send_beat(16'h0002, 1'b0, 5'd1);
    tick();
    chk("gap_we1", 32'(imem_we), 32'd0);
    tick();
    chk("gap_we2", 32'(imem_we), 32'd0);
    send_beat(16'h0003, 1'b0, 5'd2);
    send_beat(16'h0004, 1'b0, 5'd3);
    send_beat(16'h0005, 1'b1, 5'd4);
    chk("gap_prog_len", 32'(prog_len), 32'd5);
    chk("gap_loaded", 32'(loaded), 32'd1);

    // 32 beats without s_last.
    pulse_load();
    for (int i = 0; i < 32; i++) begin
      send_beat(DATA_W'(16'h4000 + i), 1'b0, ADDR_W'(i));
      if (i < 31) chk("ovf_early", 32'(overflow), 32'd0);
    end
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_loaded", 32'(loaded), 32'd0);
    chk("ovf_ready", 32'(hs.s_ready), 32'd0);
    pulse_start();
    chk("ovf_start_pc_clr", 32'(pc_clr), 32'd0);
    tick();
    chk("ovf_start_run", 32'(core_run), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reload, run to prog_len-1 twice.
    load4();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    run_plain();
    run_plain();

    // HALT opcode at PC=1.
    halt_en = 1'b1;
    halt_pc = 5'd1;
    pulse_start();
    tick();
    chk("halt_pc0_run", 32'(core_run), 32'd1);
    tick();
    chk("halt_pc1_run", 32'(core_run), 32'd1);
    chk("halt_pc1_done", 32'(done), 32'd0);
    tick();
    chk("halt_run_off", 32'(core_run), 32'd0);
    chk("halt_done", 32'(done), 32'd1);
    tick();
    chk("halt_done_once", 32'(done), 32'd0);
    halt_en = 1'b0;

    // Abort at PC=2.
    pulse_start();
    tick();
    tick();
    tick();
    chk("abort_pc2_run", 32'(core_run), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_run_off", 32'(core_run), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_loaded", 32'(loaded), 32'd1);
    tick();
    chk("abort_no_done2", 32'(done), 32'd0);
    chk("abort_stay_off", 32'(core_run), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
